// File: rtl/cpu_pkg.sv
// Shared decode/EX encodings for the multiply/divide path.
package cpu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

  // Ops that occupy the unit for more than the accept cycle.
  function automatic logic is_long_op(muldiv_op_t op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

endpackage

// File: rtl/div_core.sv
// Unsigned iterative restoring divider: one quotient bit per step, MSB first.
module div_core
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  // quotient/remainder present the result of the step taken this cycle.
  assign rem_sh    = {rem, quo[WIDTH-1]};
  assign diff      = rem_sh - {1'b0, dvs};
  assign quotient  = {quo[WIDTH-2:0], ~diff[WIDTH]};
  assign remainder = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign done      = step & (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (start) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
      cnt <= '0;
    end else if (step) begin
      rem <= remainder;
      quo <= quotient;
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit owning HI/LO; stalls the front end while busy.
module ex_muldiv
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid_i,
  input  muldiv_op_t       op_i,
  input  logic [WIDTH-1:0] rs_val_i,
  input  logic [WIDTH-1:0] rt_val_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  md_state_t          state, state_n;
  logic [WIDTH-1:0]   hi, lo, hi_n, lo_n;
  logic [WIDTH-1:0]   mul_a, mul_b;
  logic               mul_sgn, neg_q, neg_r;
  logic               cap_mul, div_start, div_step, div_done;
  logic               div_sgn;
  logic [WIDTH-1:0]   dvd_abs, dvs_abs, div_q, div_r, q_fix, r_fix;
  logic [2*WIDTH-1:0] prod;

  // Signed divide runs on magnitudes; signs are reapplied on the last step.
  assign div_sgn = (op_i == MD_DIV);
  assign dvd_abs = (div_sgn & rs_val_i[WIDTH-1]) ? WIDTH'(-rs_val_i) : rs_val_i;
  assign dvs_abs = (div_sgn & rt_val_i[WIDTH-1]) ? WIDTH'(-rt_val_i) : rt_val_i;
  assign q_fix   = neg_q ? WIDTH'(-div_q) : div_q;
  assign r_fix   = neg_r ? WIDTH'(-div_r) : div_r;

  // Sign- or zero-extend to 2*WIDTH so one multiplier serves MULT and MULTU.
  assign prod = {{WIDTH{mul_sgn & mul_a[WIDTH-1]}}, mul_a}
              * {{WIDTH{mul_sgn & mul_b[WIDTH-1]}}, mul_b};

  div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .step     (div_step),
    .dividend (dvd_abs),
    .divisor  (dvs_abs),
    .quotient (div_q),
    .remainder(div_r),
    .done     (div_done)
  );

  always_comb begin
    state_n   = state;
    hi_n      = hi;
    lo_n      = lo;
    stall_o   = 1'b0;
    cap_mul   = 1'b0;
    div_start = 1'b0;
    div_step  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (op_valid_i && !flush_i) begin
          stall_o = is_long_op(op_i);
          case (op_i)
            MD_MULT, MD_MULTU: begin
              cap_mul = 1'b1;
              state_n = ST_MUL;
            end
            MD_DIV, MD_DIVU: begin
              if (rt_val_i == '0) begin
                lo_n    = '1;
                hi_n    = rs_val_i;
                state_n = ST_DONE;
              end else begin
                div_start = 1'b1;
                state_n   = ST_DIV;
              end
            end
            MD_MTHI: hi_n = rs_val_i;
            MD_MTLO: lo_n = rs_val_i;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (flush_i) begin
          state_n = ST_IDLE;
        end else begin
          stall_o = 1'b1;
          hi_n    = prod[2*WIDTH-1:WIDTH];
          lo_n    = prod[WIDTH-1:0];
          state_n = ST_DONE;
        end
      end
      ST_DIV: begin
        if (flush_i) begin
          state_n = ST_IDLE;
        end else begin
          stall_o  = 1'b1;
          div_step = 1'b1;
          if (div_done) begin
            lo_n    = q_fix;
            hi_n    = r_fix;
            state_n = ST_DONE;
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (!rst_n) stall_o = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      hi      <= '0;
      lo      <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_sgn <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      state <= state_n;
      hi    <= hi_n;
      lo    <= lo_n;
      if (cap_mul) begin
        mul_a   <= rs_val_i;
        mul_b   <= rt_val_i;
        mul_sgn <= (op_i == MD_MULT);
      end
      if (div_start) begin
        neg_q <= div_sgn & (rs_val_i[WIDTH-1] ^ rt_val_i[WIDTH-1]);
        neg_r <= div_sgn & rs_val_i[WIDTH-1];
      end
    end
  end

  assign busy_o = (state != ST_IDLE);
  assign hi_o   = hi;
  assign lo_o   = lo;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: arithmetic reference model, randomized ops.
module tb_ex_muldiv;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  muldiv_op_t  op;
  logic [31:0] rs, rt;
  logic        flush;
  logic        stall, busy;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid_i(op_valid),
    .op_i      (op),
    .rs_val_i  (rs),
    .rt_val_i  (rt),
    .flush_i   (flush),
    .stall_o   (stall),
    .busy_o    (busy),
    .hi_o      (hi),
    .lo_o      (lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          stall;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;
  int          scnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero.
  function automatic void model(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output int st);
    longint      sp, sq, sr;
    logic [63:0] up;
    h  = mhi;
    l  = mlo;
    st = 0;
    case (o)
      MD_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        h = sp[63:32]; l = sp[31:0]; st = 2;
      end
      MD_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        h = up[63:32]; l = up[31:0]; st = 2;
      end
      MD_DIV, MD_DIVU: begin
        if (b == 32'd0) begin
          l = 32'hFFFF_FFFF; h = a; st = 1;
        end else if (o == MD_DIV) begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          l = sq[31:0]; h = sr[31:0]; st = 33;
        end else begin
          l = a / b; h = a % b; st = 33;
        end
      end
      MD_MTHI: h = a;
      MD_MTLO: l = a;
      default: ;
    endcase
  endfunction

  // Issue one instruction, holding it in EX until the unit stops stalling.
  task automatic do_op(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] h, l;
    int          st, n;
    logic        s;
    exp_t        e;
    model(o, a, b, h, l, st);
    @(negedge clk);
    op_valid = 1'b1; op = o; rs = a; rt = b;
    if (st > 0) begin
      e.hi = h; e.lo = l; e.stall = st;
      sbq.push_back(e);
    end
    mhi = h; mlo = l;
    n = 0;
    forever begin
      #1 s = stall;
      @(posedge clk);
      if (!s) break;
      n++;
      if (n > 100) begin
        errors++; checks++;
        $display("FAIL op_timeout: stall still 1 after %0d cycles, required release", n);
        break;
      end
      @(negedge clk);
    end
    #1 op_valid = 1'b0; op = MD_NONE;
    if (st == 0) begin
      @(negedge clk); #2;
      chk("mt_hi", hi, mhi);
      chk("mt_lo", lo, mlo);
    end
  endtask

  // Monitor: compares HI/LO and stall length whenever the unit sits in DONE.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_n) scnt = 0;
    else if (stall) scnt++;
    else if (busy && !flush) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected: got completion hi=0x%08h lo=0x%08h, required none", hi, lo);
      end else begin
        e = sbq.pop_front();
        chk("sb_hi", hi, e.hi);
        chk("sb_lo", lo, e.lo);
        chk("sb_stall_len", 32'(scnt), 32'(e.stall));
      end
      scnt = 0;
    end else scnt = 0;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pick_val();
    logic [31:0] sp[6];
    sp = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd1, 32'hFFFF_FFFE, 32'd7};
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return $urandom_range(0, 300);
      2: return sp[$urandom_range(0, 5)];
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    muldiv_op_t ops[6];
    ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO};
    rst_n = 1'b0; flush = 1'b0;
    op_valid = 1'b1; op = MD_DIV; rs = 32'd100; rt = 32'd7;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1; op_valid = 1'b0; op = MD_NONE;

    do_op(MD_MULT,  32'hFFFF_FFFD, 32'd5);
    do_op(MD_MULTU, 32'hFFFF_FFFD, 32'd5);
    do_op(MD_DIVU,  32'd100, 32'd7);
    do_op(MD_DIV,   32'hFFFF_FFF9, 32'd2);
    do_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    do_op(MD_DIVU,  32'd9, 32'd0);
    do_op(MD_DIVU,  32'd12345, 32'd17);
    do_op(MD_MULT,  32'd6, 32'hFFFF_FFF0);
    do_op(MD_MTHI,  32'hDEAD_BEEF, 32'd0);
    do_op(MD_MTLO,  32'h1234_5678, 32'd0);

    // Flush a signed divide at iteration 10: nothing may reach HI/LO.
    @(negedge clk);
    op_valid = 1'b1; op = MD_DIV; rs = 32'h0001_0000; rt = 32'd3;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk); #2;
    chk("flush_stall", 32'(stall), 32'd0);
    @(posedge clk); #1 flush = 1'b0; op_valid = 1'b0; op = MD_NONE;
    @(negedge clk); #2;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_hi", hi, 32'hDEAD_BEEF);
    chk("flush_lo", lo, 32'h1234_5678);
    do_op(MD_MULT, 32'd3, 32'd4);

    // Reset in the middle of a divide.
    @(negedge clk);
    op_valid = 1'b1; op = MD_DIVU; rs = 32'd50; rt = 32'd3;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0; op_valid = 1'b0; op = MD_NONE;
    @(posedge clk);
    @(negedge clk); #2;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    mhi = '0; mlo = '0;
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 40; i++) begin
      do_op(ops[$urandom_range(0, 5)], pick_val(), pick_val());
    end

    repeat (4) @(posedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
